// File: rtl/seq_frame_arbiter.sv
// seq_frame_arbiter: shares one 12-bit serial frame line between NREQ requesters.
// Round-robin by default; define FIXED_PRIO_EN for lowest-index-wins priority.
module seq_frame_arbiter #(
    parameter int NREQ = 4,
    parameter int GAP  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hab,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] c_in,
    input  logic [4*NREQ-1:0] b_in,
    input  logic [NREQ-1:0]   bp_in,
    input  logic [NREQ-1:0]   cod_in,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              done,
    output logic              o
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      bit_idx_q, bit_idx_d;
    logic [3:0]      gap_cnt_q, gap_cnt_d;
    logic [11:0]     frame_q, frame_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            o_q, o_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [PW-1:0]   win;
    logic            win_vld;

`ifdef FIXED_PRIO_EN
    always_comb begin
        win = '0;
        win_vld = |req;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[k]) win = PW'(k);
    end
`else
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;

    // Scan downward so the nearest requester after rr_ptr is assigned last and wins.
    always_comb begin
        win = '0;
        win_vld = |req;
        for (int k = NREQ; k >= 1; k--)
            if (req[(int'(rr_ptr_q) + k) % NREQ]) win = PW'((int'(rr_ptr_q) + k) % NREQ);
    end

    always_comb rr_ptr_d = (state_q == S_IDLE && hab && win_vld) ? win : rr_ptr_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rr_ptr_q <= PW'(NREQ - 1);
        else rr_ptr_q <= rr_ptr_d;
`endif

    // The frame is shifted left each bit, so the next bit to send always sits at [10].
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        gap_cnt_d = gap_cnt_q;
        frame_d   = frame_q;
        gnt_d     = '0;
        o_d       = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (hab && win_vld) begin
                    gnt_d[win] = 1'b1;
                    frame_d    = {1'b1, c_in[4*int'(win) +: 4], b_in[4*int'(win) +: 4],
                                  bp_in[win], ~cod_in[win], ~cod_in[win]};
                    o_d        = 1'b1;
                    busy_d     = 1'b1;
                    bit_idx_d  = '0;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                if (bit_idx_q == 4'd11) begin
                    done_d    = 1'b1;
                    bit_idx_d = '0;
                    gap_cnt_d = '0;
                    state_d   = (GAP > 0) ? S_GAP : S_IDLE;
                    busy_d    = (GAP > 0);
                end else begin
                    o_d       = frame_q[10];
                    frame_d   = frame_q << 1;
                    bit_idx_d = bit_idx_q + 4'd1;
                end
            end
            S_GAP: begin
                // The done cycle is counted as the first GAP-state cycle.
                if (gap_cnt_q == 4'(GAP)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bit_idx_q <= '0;
            gap_cnt_q <= '0;
            frame_q   <= '0;
            gnt_q     <= '0;
            o_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            gap_cnt_q <= gap_cnt_d;
            frame_q   <= frame_d;
            gnt_q     <= gnt_d;
            o_q       <= o_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign gnt  = gnt_q;
    assign o    = o_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_seq_frame_arbiter.sv
// tb_seq_frame_arbiter: directed checks of the frame arbiter (GAP=1 and GAP=0 instances).
module tb_seq_frame_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hab = 1'b0, hab2 = 1'b0;
    logic [3:0]  req = '0, req2 = '0;
    logic [15:0] c_in = '0, b_in = '0;
    logic [3:0]  bp_in = '0, cod_in = '0;
    logic [3:0]  gnt, gnt2;
    logic        busy, done, o, busy2, done2, o2;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    seq_frame_arbiter #(.NREQ(4), .GAP(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .hab(hab), .req(req), .c_in(c_in), .b_in(b_in),
        .bp_in(bp_in), .cod_in(cod_in), .gnt(gnt), .busy(busy), .done(done), .o(o));

    seq_frame_arbiter #(.NREQ(4), .GAP(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .hab(hab2), .req(req2), .c_in(c_in), .b_in(b_in),
        .bp_in(bp_in), .cod_in(cod_in), .gnt(gnt2), .busy(busy2), .done(done2), .o(o2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Called at the sample point where the start bit is visible.
    task automatic finish_frame(input logic [11:0] bits, input int drop_at);
        for (int i = 1; i < 12; i++) begin
            tick;
            if (i == drop_at) hab = 1'b0;
            chk($sformatf("bit%0d", i), o, bits[11-i]);
            if (i == 1) chk("gnt_pulse", gnt, 0);
        end
        tick;
        chk("done_o", o, 0);
        chk("done", done, 1);
        chk("done_busy", busy, 1);
        tick;
        chk("gap_done", done, 0);
        chk("gap_busy", busy, 1);
        tick;
        chk("idle_busy", busy, 0);
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy !== 1'b0 && n < 50) begin tick; n++; end
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        int cnt;
        logic any_g, any_o;
        // 1: reset
        req = 4'hf;
        hab = 1'b1;
        tick; tick;
        chk("rst_o", o, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_gnt2", gnt2, 0);
        rst_n = 1'b1;
        tick;
        chk("first_gnt", gnt, 4'b0001);
        chk("first_o", o, 1);
        chk("first_busy", busy, 1);
        req = '0;
        finish_frame(12'h803, 0);
        // 2: single frame, fields changed mid-frame must not matter
        c_in[3:0] = 4'b1010; b_in[3:0] = 4'b0011; bp_in[0] = 1'b1; cod_in[0] = 1'b0;
        req = 4'b0001;
        tick;
        chk("single_gnt", gnt, 4'b0001);
        chk("single_start", o, 1);
        req = '0;
        c_in[3:0] = 4'b0101; b_in[3:0] = 4'b1100; bp_in[0] = 1'b0; cod_in[0] = 1'b1;
        finish_frame(12'b1101_0001_1111, 0);
        // 3: round robin after fresh reset
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        req = 4'hf;
        for (int n = 0; n < 5; n++) begin
            cnt = 0;
            do begin
                tick;
                cnt++;
                if (gnt == 0) req = 4'hf;
            end while (gnt == 0 && cnt < 40);
            chk($sformatf("rr_gnt%0d", n), gnt, 1 << (n % 4));
            if (n > 0) chk($sformatf("rr_gap%0d", n), cnt, 15);
            req = req & ~gnt;
        end
        req = '0;
        wait_idle;
        // 4: hab gating
        c_in[11:8] = 4'b0110; b_in[11:8] = 4'b1001; bp_in[2] = 1'b0; cod_in[2] = 1'b1;
        hab = 1'b0;
        req = 4'b0100;
        any_g = 1'b0; any_o = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            any_g |= |gnt;
            any_o |= o;
        end
        chk("hab0_gnt", any_g, 0);
        chk("hab0_o", any_o, 0);
        hab = 1'b1;
        tick;
        chk("hab1_gnt", gnt, 4'b0100);
        finish_frame(12'b1011_0100_1000, 5);
        any_g = 1'b0;
        for (int i = 0; i < 5; i++) begin tick; any_g |= |gnt; end
        chk("hab_drop_nognt", any_g, 0);
        // 5: reset mid-frame
        req = '0;
        c_in[3:0] = 4'b0000; b_in[3:0] = 4'b0100; bp_in[0] = 1'b0; cod_in[0] = 1'b0;
        hab = 1'b1;
        req = 4'b0011;
        tick;
        chk("mid_gnt", gnt, 4'b0001);
        for (int i = 0; i < 6; i++) tick;
        chk("mid_bit6", o, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_o", o, 0);
        chk("mid_rst_busy", busy, 0);
        any_g = 1'b0;
        for (int i = 0; i < 3; i++) begin tick; any_g |= done; end
        chk("mid_rst_done", any_g, 0);
        rst_n = 1'b1;
        tick;
        chk("post_rst_gnt", gnt, 4'b0001);
        req = '0;
        finish_frame(12'h823, 0);
        // 6: GAP=0 instance, req held
        hab2 = 1'b1;
        req2 = 4'b0110;
        for (int n = 0; n < 4; n++) begin
            cnt = 0;
            any_g = 1'b0;
            do begin
                tick;
                cnt++;
                if (cnt == 12) any_g = done2 & ~o2;
            end while (gnt2 == 0 && cnt < 40);
`ifdef FIXED_PRIO_EN
            chk($sformatf("g0_gnt%0d", n), gnt2, 4'b0010);
`else
            chk($sformatf("g0_gnt%0d", n), gnt2, (n % 2 == 0) ? 4'b0010 : 4'b0100);
`endif
            if (n > 0) begin
                chk($sformatf("g0_gap%0d", n), cnt, 13);
                chk($sformatf("g0_done%0d", n), any_g, 1);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
